hilo_muldiv: RTL and testbench

Execute-stage multiply/divide unit that owns the architectural HI/LO registers. It consumes the E-stage HI/LO control (hilowriteE, hiloselE, ifhiloE) plus an operation code and the forwarded operands. It performs single-cycle mult/multu, iterative 32-step div/divu, and mthi/mtlo. It stalls the pipeline while a divide is in progress and supplies the HI or LO value for mfhi/mflo.

---
 rtl/hilo_muldiv.sv | 154 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Optional build macro MULT_2CYCLE_EN: registered multiply with a one-cycle issue stall.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flushE,
    input  logic             hilowriteE,
    input  logic             hiloselE,
    input  logic             ifhiloE,
    input  logic [2:0]       mdopE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic             stallE,
    output logic [WIDTH-1:0] hilo_rdataE,
    output logic             busyE
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTX   = 3'd5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] divRem, divQuo, divisor;
    logic             quoNeg, remNeg, divZero;

    logic             accept, isMult, isDiv, signedDiv;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] aAbs, bAbs;
    logic [WIDTH:0]   remShift, diff;
    logic [WIDTH-1:0] nextRem, nextQuo, quoFinal, remFinal;

    // mfhi/mflo read the registered value only; the read strobe is not needed.
    logic unusedIfhilo;
    assign unusedIfhilo = ifhiloE;

    assign accept    = hilowriteE & ~flushE & (state == IDLE);
    assign isMult    = (mdopE == OP_MULT) | (mdopE == OP_MULTU);
    assign isDiv     = (mdopE == OP_DIV) | (mdopE == OP_DIVU);
    assign signedDiv = (mdopE == OP_DIV);

    always_comb begin
        prod = '0;
        if (mdopE == OP_MULT)
            prod = {{WIDTH{srcaE[WIDTH-1]}}, srcaE} * {{WIDTH{srcbE[WIDTH-1]}}, srcbE};
        else
            prod = {{WIDTH{1'b0}}, srcaE} * {{WIDTH{1'b0}}, srcbE};
    end

    always_comb begin
        aAbs = srcaE;
        bAbs = srcbE;
        if (signedDiv && srcaE[WIDTH-1]) aAbs = -srcaE;
        if (signedDiv && srcbE[WIDTH-1]) bAbs = -srcbE;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        remShift = {divRem, divQuo[WIDTH-1]};
        diff     = remShift - {1'b0, divisor};
        nextRem  = remShift[WIDTH-1:0];
        nextQuo  = {divQuo[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            nextRem = diff[WIDTH-1:0];
            nextQuo = {divQuo[WIDTH-2:0], 1'b1};
        end
        quoFinal = (quoNeg && !divZero) ? -nextQuo : nextQuo;
        remFinal = (remNeg && !divZero) ? -nextRem : nextRem;
    end

    always_comb begin
        stallE = 1'b0;
        case (state)
`ifdef MULT_2CYCLE_EN
            IDLE:    stallE = accept & (isDiv | isMult);
`else
            IDLE:    stallE = accept & isDiv;
`endif
            BUSY:    stallE = 1'b1;
            default: stallE = 1'b0;
        endcase
    end

    assign busyE       = (state == BUSY);
    assign hilo_rdataE = hiloselE ? hi : lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            hi      <= '0;
            lo      <= '0;
            divRem  <= '0;
            divQuo  <= '0;
            divisor <= '0;
            quoNeg  <= 1'b0;
            remNeg  <= 1'b0;
            divZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (isMult) begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
`ifdef MULT_2CYCLE_EN
                            state <= DONE;
`endif
                        end else if (isDiv) begin
                            divRem  <= '0;
                            divQuo  <= aAbs;
                            divisor <= bAbs;
                            quoNeg  <= signedDiv & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                            remNeg  <= signedDiv & srcaE[WIDTH-1];
                            divZero <= (srcbE == '0);
                            counter <= '0;
                            state   <= BUSY;
                        end else if (mdopE == OP_MTX) begin
                            if (hiloselE) hi <= srcaE;
                            else          lo <= srcaE;
                        end
                    end
                end
                BUSY: begin
                    if (flushE) begin
                        state <= IDLE;
                    end else begin
                        divRem  <= nextRem;
                        divQuo  <= nextQuo;
                        counter <= counter + 1'b1;
                        if (counter == CW'(WIDTH-1)) begin
                            hi    <= remFinal;
                            lo    <= quoFinal;
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases plus random ops against an arithmetic model.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        flushE, hilowriteE, hiloselE, ifhiloE;
    logic [2:0]  mdopE;
    logic [31:0] srcaE, srcbE;
    logic        stallE, busyE;
    logic [31:0] hilo_rdataE;

    int cmps = 0;
    int errs = 0;
    logic [31:0] mHi = '0, mLo = '0;

`ifdef MULT_2CYCLE_EN
    localparam int MULT_STALL = 1;
`else
    localparam int MULT_STALL = 0;
`endif

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flushE(flushE), .hilowriteE(hilowriteE),
        .hiloselE(hiloselE), .ifhiloE(ifhiloE), .mdopE(mdopE),
        .srcaE(srcaE), .srcbE(srcbE), .stallE(stallE),
        .hilo_rdataE(hilo_rdataE), .busyE(busyE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural result of an op, straight from the arithmetic definition.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic sel);
        longint sa, sb, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin q = sa * sb; mHi = q[63:32]; mLo = q[31:0]; end
            3'd2: begin up = ua * ub; mHi = up[63:32]; mLo = up[31:0]; end
            3'd3: begin
                if (b == 0) begin
                    q = (sa < 0) ? -sa : sa;
                    mHi = q[31:0]; mLo = 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb; r = sa % sb;
                    mHi = r[31:0]; mLo = q[31:0];
                end
            end
            3'd4: begin
                if (b == 0) begin mHi = a; mLo = 32'hFFFF_FFFF; end
                else begin up = ua / ub; mLo = up[31:0]; up = ua % ub; mHi = up[31:0]; end
            end
            3'd5: if (sel) mHi = a; else mLo = a;
            default: ;
        endcase
    endtask

    task automatic idle_inputs();
        flushE = 1'b0; hilowriteE = 1'b0; mdopE = 3'd0; ifhiloE = 1'b0;
    endtask

    task automatic read_hilo(input string tag);
        @(negedge clk);
        idle_inputs();
        ifhiloE = 1'b1;
        hiloselE = 1'b1; #1;
        check({tag, "_hi"}, hilo_rdataE, mHi);
        hiloselE = 1'b0; #1;
        check({tag, "_lo"}, hilo_rdataE, mLo);
        check({tag, "_nostall"}, {31'd0, stallE}, 32'd0);
    endtask

    // Issue one HI/LO-writing op and count how many cycles it holds the pipeline.
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic sel, input logic flush, input int expStall);
        int n;
        @(negedge clk);
        mdopE = op; hilowriteE = 1'b1; srcaE = a; srcbE = b; hiloselE = sel; flushE = flush;
        #1;
        n = 0;
        while (stallE === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            flushE = 1'b0;
            #1;
        end
        check({tag, "_stall"}, 32'(n), 32'(expStall));
        if (!flush) model(op, a, b, sel);
        if (n > 0 && !flush) begin
            hiloselE = 1'b1; #1;
            check({tag, "_done_hi"}, hilo_rdataE, mHi);
            hiloselE = 1'b0; #1;
            check({tag, "_done_lo"}, hilo_rdataE, mLo);
        end
        @(posedge clk);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        fl;
        int          st;

        rst = 1'b1; idle_inputs(); hiloselE = 1'b0; srcaE = '0; srcbE = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        check("reset_busy", {31'd0, busyE}, 32'd0);
        read_hilo("reset");

        issue("mult", 3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, MULT_STALL);
        read_hilo("mult");
        check("mult_hi_const", mHi, 32'hFFFF_FFFF);
        issue("multu", 3'd2, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, MULT_STALL);
        read_hilo("multu");

        issue("div_m7_2", 3'd3, -32'sd7, 32'd2, 1'b0, 1'b0, 33);
        read_hilo("div_m7_2");
        issue("divu_100_7", 3'd4, 32'd100, 32'd7, 1'b0, 1'b0, 33);
        issue("mult_after_done", 3'd2, 32'd3, 32'd5, 1'b0, 1'b0, MULT_STALL);
        read_hilo("mult_after_done");
        issue("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
        issue("divu_5_0", 3'd4, 32'd5, 32'd0, 1'b0, 1'b0, 33);
        read_hilo("divu_5_0");

        // Flush on BUSY cycle 10: divide is abandoned, HI/LO keep prior values.
        @(negedge clk);
        mdopE = 3'd4; hilowriteE = 1'b1; srcaE = 32'd100; srcbE = 32'd7;
        repeat (11) @(negedge clk);
        flushE = 1'b1; #1;
        check("flush_cycle_stall", {31'd0, stallE}, 32'd1);
        check("flush_cycle_busy", {31'd0, busyE}, 32'd1);
        @(negedge clk);
        idle_inputs(); #1;
        check("post_flush_stall", {31'd0, stallE}, 32'd0);
        check("post_flush_busy", {31'd0, busyE}, 32'd0);
        read_hilo("post_flush");

        // Reset mid-divide.
        @(negedge clk);
        mdopE = 3'd3; hilowriteE = 1'b1; srcaE = 32'd1000; srcbE = 32'd3;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; idle_inputs(); #1;
        mHi = '0; mLo = '0;
        check("rst_mid_busy", {31'd0, busyE}, 32'd0);
        check("rst_mid_stall", {31'd0, stallE}, 32'd0);
        read_hilo("rst_mid");

        issue("mthi", 3'd5, 32'h1234, 32'd0, 1'b1, 1'b0, 0);
        read_hilo("mthi");
        issue("mtlo_flushed", 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 0);
        read_hilo("mtlo_flushed");
        issue("mult_flushed", 3'd1, 32'h7, 32'h9, 1'b0, 1'b1, 0);
        read_hilo("mult_flushed");

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 5));
            a  = $urandom;
            b  = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            fl = ($urandom_range(0, 7) == 0);
            if (fl) st = 0;
            else if (op == 3'd3 || op == 3'd4) st = 33;
            else if (op == 3'd5) st = 0;
            else st = MULT_STALL;
            issue("rand", op, a, b, 1'($urandom_range(0, 1)), fl, st);
            read_hilo("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
